// File: rtl/ct_lsu_lq_alloc.sv
// Load-queue entry allocator: picks up to two free entries for a DC-stage load,
// tracks occupancy/full state and registers RAR/RAW speculation failures.
// Optional LSU_LQ_SPEC_STAT_EN adds saturating spec-fail statistics counters.
`default_nettype none

module ct_lsu_lq_alloc (
  input  logic        lq_clk,
  input  logic        cpurst_b,
  input  logic        rtu_yy_xx_flush,
  input  logic        ld_dc_create_req,
  input  logic        ld_dc_create1_req,
  input  logic [6:0]  ld_dc_iid,
  input  logic [6:0]  st_dc_iid,
  input  logic [15:0] lq_entry_vld,
  input  logic [15:0] lq_entry_inst_hit,
  input  logic [15:0] lq_entry_rar_spec_fail,
  input  logic [15:0] lq_entry_raw_spec_fail,
  output logic [15:0] lq_entry_create0_vld,
  output logic [15:0] lq_entry_create1_vld,
  output logic        lq_ld_dc_full,
  output logic        ld_da_lq_rar_spec_fail,
  output logic [6:0]  ld_da_lq_iid,
  output logic        st_da_lq_raw_spec_fail,
  output logic [6:0]  st_da_lq_iid,
  output logic [4:0]  lq_cnt,
  output logic        lq_full_stall,
  output logic [15:0] lq_rar_fail_cnt,
  output logic [15:0] lq_raw_fail_cnt
);

  typedef enum logic [0:0] {IDLE = 1'b0, FULL = 1'b1} state_t;

  logic [15:0] free_vec;
  logic [15:0] slot0_oh;
  logic [15:0] rest_vec;
  logic [15:0] slot1_oh;
  logic [4:0]  free_cnt;
  logic [1:0]  need;
  logic        alloc_ok;
  logic        rar_fail_nxt;
  logic        raw_fail_nxt;
  state_t      state;

  always_comb begin
    free_vec = ~lq_entry_vld;
    free_cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      free_cnt = free_cnt + {4'd0, free_vec[i]};
    end
    // Two's-complement trick isolates the lowest set bit.
    slot0_oh = free_vec & (~free_vec + 16'd1);
    rest_vec = free_vec & ~slot0_oh;
    slot1_oh = rest_vec & (~rest_vec + 16'd1);

    need = 2'd0;
    if (ld_dc_create_req && (lq_entry_inst_hit == 16'd0)) begin
      need = ld_dc_create1_req ? 2'd2 : 2'd1;
    end

    alloc_ok             = !rtu_yy_xx_flush && (need != 2'd0) && (free_cnt >= {3'd0, need});
    lq_ld_dc_full        = !rtu_yy_xx_flush && (need != 2'd0) && (free_cnt <  {3'd0, need});
    lq_entry_create0_vld = alloc_ok ? slot0_oh : 16'd0;
    lq_entry_create1_vld = (alloc_ok && (need == 2'd2)) ? slot1_oh : 16'd0;

    rar_fail_nxt = (|lq_entry_rar_spec_fail) && !rtu_yy_xx_flush;
    raw_fail_nxt = (|lq_entry_raw_spec_fail) && !rtu_yy_xx_flush;
  end

  always_ff @(posedge lq_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state         <= IDLE;
      lq_full_stall <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (lq_ld_dc_full) begin
            state         <= FULL;
            lq_full_stall <= 1'b1;
          end
        end
        FULL: begin
          if ((free_cnt >= 5'd2) || rtu_yy_xx_flush) begin
            state         <= IDLE;
            lq_full_stall <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          lq_full_stall <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge lq_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      lq_cnt                 <= 5'd0;
      ld_da_lq_rar_spec_fail <= 1'b0;
      ld_da_lq_iid           <= 7'd0;
      st_da_lq_raw_spec_fail <= 1'b0;
      st_da_lq_iid           <= 7'd0;
    end else begin
      lq_cnt                 <= rtu_yy_xx_flush ? 5'd0 : (5'd16 - free_cnt);
      ld_da_lq_rar_spec_fail <= rar_fail_nxt;
      st_da_lq_raw_spec_fail <= raw_fail_nxt;
      if (rar_fail_nxt) begin
        ld_da_lq_iid <= ld_dc_iid;
      end
      if (raw_fail_nxt) begin
        st_da_lq_iid <= st_dc_iid;
      end
    end
  end

`ifdef LSU_LQ_SPEC_STAT_EN
  always_ff @(posedge lq_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      lq_rar_fail_cnt <= 16'd0;
      lq_raw_fail_cnt <= 16'd0;
    end else begin
      if (ld_da_lq_rar_spec_fail && (lq_rar_fail_cnt != 16'hFFFF)) begin
        lq_rar_fail_cnt <= lq_rar_fail_cnt + 16'd1;
      end
      if (st_da_lq_raw_spec_fail && (lq_raw_fail_cnt != 16'hFFFF)) begin
        lq_raw_fail_cnt <= lq_raw_fail_cnt + 16'd1;
      end
    end
  end
`else
  assign lq_rar_fail_cnt = 16'h0;
  assign lq_raw_fail_cnt = 16'h0;
`endif

endmodule

`default_nettype wire

// File: doc/ct_lsu_lq_alloc.md
CT_LSU_LQ_ALLOC -- requirements
Module: ct_lsu_lq_alloc

Interface
REQ-001 SHALL: lq_clk  in  1  clock, all state on rising edge.
REQ-002 SHALL: cpurst_b  in  1  reset, asynchronous, active-low.
REQ-003 SHALL: rtu_yy_xx_flush  in  1  pipeline flush.
REQ-004 SHALL: ld_dc_create_req  in  1  load in DC needs an entry for addr0.
REQ-005 SHALL: ld_dc_create1_req  in  1  load also needs an entry for addr1 (cross-line; ignored unless ld_dc_create_req).
REQ-006 SHALL: ld_dc_iid / st_dc_iid  in  7 each  DC-stage instruction ids.
REQ-007 SHALL: lq_entry_vld / lq_entry_inst_hit / lq_entry_rar_spec_fail / lq_entry_raw_spec_fail  in  16 each  per-entry status.
REQ-008 SHALL: lq_entry_create0_vld / lq_entry_create1_vld  out  16 each  one-hot entry allocate strobes (also drive dp_vld and gateclk_en).
REQ-009 SHALL: lq_ld_dc_full  out  1  combinational; create refused, load replays.
REQ-010 SHALL: ld_da_lq_rar_spec_fail, ld_da_lq_iid  out  1, 7  registered RAR result for DA stage.
REQ-011 SHALL: st_da_lq_raw_spec_fail, st_da_lq_iid  out  1, 7  registered RAW result for DA stage.
REQ-012 SHALL: lq_cnt  out  5  registered count of valid entries, 0..16.
REQ-013 SHALL: lq_full_stall  out  1  registered; 1 while FSM in FULL.

Function
REQ-014 SHALL: free vector = ~lq_entry_vld; slot0 = lowest-index free bit, slot1 = second-lowest free bit.
REQ-015 SHALL: need = 1 if create_req and !create1_req, 2 if both, 0 otherwise; any lq_entry_inst_hit bit forces need = 0 (entry already exists).
REQ-016 SHALL: if popcount(free) >= need and need > 0 and !flush: create0_vld = onehot(slot0); create1_vld = onehot(slot1) only if need == 2; same cycle, zero latency.
REQ-017 SHALL: if popcount(free) < need: both create vectors 0, lq_ld_dc_full = 1; a partial (1-of-2) allocation SHALL never occur.
REQ-018 SHALL: flush forces create vectors 0 and lq_ld_dc_full 0 in the same cycle.
REQ-019 SHALL: lq_cnt next = popcount(lq_entry_vld) sampled each cycle (1-cycle lag); flush sets it to 0.
REQ-020 SHALL: FSM IDLE -> FULL when lq_ld_dc_full; FULL -> IDLE when popcount(free) >= 2 or flush; lq_full_stall = (state == FULL).
REQ-021 SHALL: ld_da_lq_rar_spec_fail next = |lq_entry_rar_spec_fail & !flush; ld_da_lq_iid next = ld_dc_iid when any fail, else hold; pulse lasts exactly 1 cycle.
REQ-022 SHALL: st_da_lq_raw_spec_fail / st_da_lq_iid same rule using raw vector and st_dc_iid.
REQ-023 SHALL: RAR and RAW fails in the same cycle SHALL both be registered independently.
REQ-024 SHALL: behaviour when entry vld bits clear and create in the same cycle is defined solely by lq_entry_vld as sampled (popped slots reusable next cycle only).

Reset
REQ-025 SHALL: on cpurst_b low: lq_cnt 0, FSM IDLE, lq_full_stall 0, both spec_fail 0, both DA iids 0, stat counters 0.
REQ-026 SHALL: reset asserted mid-allocation discards the request; no create strobe after deassertion without a new request.

Configuration
REQ-027 SHALL: macro LSU_LQ_SPEC_STAT_EN defined: 16-bit saturating counters lq_rar_fail_cnt, lq_raw_fail_cnt (outputs) increment once per cycle with the respective registered fail, hold at 16'hFFFF, unaffected by flush.
REQ-028 SHALL: macro undefined: counters absent, both outputs tied to 16'h0.

Verification
REQ-029 SHALL: vld=16'h0000, create_req=1, create1_req=1 -> create0=16'h0001, create1=16'h0002, full=0.
REQ-030 SHALL: vld=16'hFFFE, create_req=1, create1_req=1 -> creates 0, full=1; next cycle lq_full_stall=1; vld=16'h7FFE next -> stall clears following cycle.
REQ-031 SHALL: inst_hit=16'h0010, create_req=1 -> creates 0, full=0.
REQ-032 SHALL: rar_spec_fail=16'h0100, ld_dc_iid=7'h23 -> next cycle ld_da_lq_rar_spec_fail=1, ld_da_lq_iid=7'h23, following cycle 0.
REQ-033 SHALL: raw fail with flush same cycle -> st_da_lq_raw_spec_fail stays 0; lq_cnt=0 next cycle.
REQ-034 SHALL: LSU_LQ_SPEC_STAT_EN defined, counter preloaded to 16'hFFFF by 65535 fails, one more fail -> stays 16'hFFFF.
